// File: rtl/bcd_3digit_decrementer.sv
// Purpose: three-digit BCD down-counter with load, start/stop control and optional auto-reload.
// Latency: count and done update one cycle after the load/tick that causes them; zero follows q combinationally.
// Backpressure: none; tick is a single-cycle enable and is only honoured in RUN.
module bcd_3digit_decrementer #(
    parameter int RELOAD = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load0,
    input  logic [3:0] load1,
    input  logic [3:0] load2,
    input  logic       start,
    input  logic       stop,
    input  logic       tick,
    output logic [3:0] q0,
    output logic [3:0] q1,
    output logic [3:0] q2,
    output logic       running,
    output logic       zero,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] q0_q, q1_q, q2_q;
    logic [3:0] q0_d, q1_d, q2_d;
    logic [3:0] rl0_q, rl1_q, rl2_q;
    logic [3:0] rl0_d, rl1_d, rl2_d;
    logic       done_q, done_d;
    // Set after a terminal count in reload mode: the next tick restores the saved value.
    logic       pend_q, pend_d;

    logic [3:0] ld0, ld1, ld2;
    logic [3:0] dec0, dec1, dec2;
    logic       borrow0, borrow1;
    logic       cnt_zero, cnt_one, rl_zero;

    // Out-of-range load digits saturate to 9 so the count is always valid BCD.
    function automatic logic [3:0] clamp_digit(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    // Clamped load digits and status decodes of the current count.
    always_comb begin
        ld0      = clamp_digit(load0);
        ld1      = clamp_digit(load1);
        ld2      = clamp_digit(load2);
        cnt_zero = (q2_q == 4'd0) && (q1_q == 4'd0) && (q0_q == 4'd0);
        cnt_one  = (q2_q == 4'd0) && (q1_q == 4'd0) && (q0_q == 4'd1);
        rl_zero  = (rl2_q == 4'd0) && (rl1_q == 4'd0) && (rl0_q == 4'd0);
    end

    // Ripple-borrow decrement: a digit only changes when every lower digit was 0.
    always_comb begin
        dec0    = (q0_q == 4'd0) ? 4'd9 : q0_q - 4'd1;
        borrow0 = (q0_q == 4'd0);
        dec1    = q1_q;
        if (borrow0) begin
            dec1 = (q1_q == 4'd0) ? 4'd9 : q1_q - 4'd1;
        end
        borrow1 = borrow0 && (q1_q == 4'd0);
        dec2    = q2_q;
        if (borrow1) begin
            dec2 = (q2_q == 4'd0) ? 4'd9 : q2_q - 4'd1;
        end
    end

    // Next-state, count and done logic; load overrides everything, stop overrides start/tick.
    always_comb begin
        state_d = state_q;
        q0_d    = q0_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        rl0_d   = rl0_q;
        rl1_d   = rl1_q;
        rl2_d   = rl2_q;
        pend_d  = pend_q;
        done_d  = 1'b0;

        if (load) begin
            q0_d    = ld0;
            q1_d    = ld1;
            q2_d    = ld2;
            rl0_d   = ld0;
            rl1_d   = ld1;
            rl2_d   = ld2;
            pend_d  = 1'b0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    pend_d = 1'b0;
                    if (start && !stop && !cnt_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        pend_d  = 1'b0;
                        state_d = IDLE;
                    end else if (tick) begin
                        if (pend_q) begin
                            q0_d   = rl0_q;
                            q1_d   = rl1_q;
                            q2_d   = rl2_q;
                            pend_d = 1'b0;
                        end else if (cnt_one) begin
                            q0_d   = 4'd0;
                            done_d = 1'b1;
                            if ((RELOAD == 0) || rl_zero) begin
                                state_d = IDLE;
                            end else begin
                                pend_d = 1'b1;
                            end
                        end else if (cnt_zero) begin
                            // Never decrement past 000; drop back to IDLE instead.
                            state_d = IDLE;
                        end else begin
                            q0_d = dec0;
                            q1_d = dec1;
                            q2_d = dec2;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, count, reload value and done registers; reset clears all immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            q0_q    <= 4'd0;
            q1_q    <= 4'd0;
            q2_q    <= 4'd0;
            rl0_q   <= 4'd0;
            rl1_q   <= 4'd0;
            rl2_q   <= 4'd0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            rl0_q   <= rl0_d;
            rl1_q   <= rl1_d;
            rl2_q   <= rl2_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    assign q0      = q0_q;
    assign q1      = q1_q;
    assign q2      = q2_q;
    assign running = (state_q == RUN);
    assign zero    = cnt_zero;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_3digit_decrementer.sv
// Purpose: directed bench for both RELOAD settings against an integer-valued reference model.
// Latency: model and DUT both update at the rising edge; outputs compared on the falling edge.
// Backpressure: not applicable.
module tb_bcd_3digit_decrementer;

    logic clk;
    logic reset_n;
    logic ld, st, sp, tk;
    logic [3:0] l0, l1, l2;

    logic [1:0][3:0] dq0, dq1, dq2;
    logic [1:0]      drun, dzero, ddone;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    bcd_3digit_decrementer #(.RELOAD(0)) u0 (
        .clk(clk), .reset_n(reset_n), .load(ld), .load0(l0), .load1(l1), .load2(l2),
        .start(st), .stop(sp), .tick(tk),
        .q0(dq0[0]), .q1(dq1[0]), .q2(dq2[0]),
        .running(drun[0]), .zero(dzero[0]), .done(ddone[0])
    );

    bcd_3digit_decrementer #(.RELOAD(1)) u1 (
        .clk(clk), .reset_n(reset_n), .load(ld), .load0(l0), .load1(l1), .load2(l2),
        .start(st), .stop(sp), .tick(tk),
        .q0(dq0[1]), .q1(dq1[1]), .q2(dq2[1]),
        .running(drun[1]), .zero(dzero[1]), .done(ddone[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counts as plain integers 0..999, index 0 = stop mode, 1 = reload mode.
    int m_cnt [2];
    int m_rl  [2];
    bit m_run [2];
    bit m_pend[2];
    bit m_done[2];

    function automatic int clampd(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 2; r++) begin
                m_cnt[r] <= 0; m_rl[r] <= 0; m_run[r] <= 0; m_pend[r] <= 0; m_done[r] <= 0;
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                m_done[r] <= 0;
                if (ld) begin
                    m_cnt[r]  <= clampd(int'(l2)) * 100 + clampd(int'(l1)) * 10 + clampd(int'(l0));
                    m_rl[r]   <= clampd(int'(l2)) * 100 + clampd(int'(l1)) * 10 + clampd(int'(l0));
                    m_run[r]  <= 0;
                    m_pend[r] <= 0;
                end else if (!m_run[r]) begin
                    if (start_ok(r)) m_run[r] <= 1;
                end else if (sp) begin
                    m_run[r]  <= 0;
                    m_pend[r] <= 0;
                end else if (tk) begin
                    if (m_pend[r]) begin
                        m_cnt[r]  <= m_rl[r];
                        m_pend[r] <= 0;
                    end else if (m_cnt[r] == 1) begin
                        m_cnt[r]  <= 0;
                        m_done[r] <= 1;
                        if (r == 0 || m_rl[r] == 0) m_run[r] <= 0;
                        else m_pend[r] <= 1;
                    end else begin
                        m_cnt[r] <= m_cnt[r] - 1;
                    end
                end
            end
        end
    end

    function automatic bit start_ok(input int r);
        return st && !sp && (m_cnt[r] != 0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int r = 0; r < 2; r++) begin
                chk($sformatf("model_cnt%0d", r), int'({dq2[r], dq1[r], dq0[r]}), to_bcd(m_cnt[r]));
                chk($sformatf("model_run%0d", r), int'(drun[r]), int'(m_run[r]));
                chk($sformatf("model_zero%0d", r), int'(dzero[r]), int'(m_cnt[r] == 0));
                chk($sformatf("model_done%0d", r), int'(ddone[r]), int'(m_done[r]));
            end
        end
    end

    // Apply one cycle of inputs at the falling edge; return 1ns after the next rising edge.
    task automatic step(input bit a_ld, input int v2, input int v1, input int v0,
                        input bit a_st, input bit a_sp, input bit a_tk);
        @(negedge clk);
        ld = a_ld; l2 = 4'(v2); l1 = 4'(v1); l0 = 4'(v0);
        st = a_st; sp = a_sp; tk = a_tk;
        @(posedge clk);
        #1;
        ld = 0; st = 0; sp = 0; tk = 0;
    endtask

    task automatic loadv(input int v2, input int v1, input int v0);
        step(1, v2, v1, v0, 0, 0, 0);
    endtask

    task automatic cyc(input bit a_st, input bit a_sp, input bit a_tk);
        step(0, 0, 0, 0, a_st, a_sp, a_tk);
    endtask

    function automatic int cnt_of(input int r);
        return int'({dq2[r], dq1[r], dq0[r]});
    endfunction

    initial begin
        reset_n = 0;
        ld = 0; st = 0; sp = 0; tk = 0; l0 = 0; l1 = 0; l2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", cnt_of(0), 'h000);
        chk("rst_run", int'(drun[0]), 0);
        chk("rst_zero", int'(dzero[0]), 1);
        chk("rst_done", int'(ddone[0]), 0);
        @(negedge clk);
        reset_n = 1;
        chk_en  = 1;

        // After reset, start alone must not leave IDLE at 000.
        cyc(1, 0, 0);
        chk("post_rst_start", int'(drun[0]), 0);

        // Basic countdown 003 -> 000 in stop mode.
        loadv(0, 0, 3);
        chk("t1_load", cnt_of(0), 'h003);
        cyc(1, 0, 0);
        chk("t1_run", int'(drun[0]), 1);
        cyc(0, 0, 0);
        chk("t1_hold_no_tick", cnt_of(0), 'h003);
        cyc(0, 0, 1);
        chk("t1_tick1", cnt_of(0), 'h002);
        cyc(0, 0, 1);
        chk("t1_tick2", cnt_of(0), 'h001);
        chk("t1_nodone", int'(ddone[0]), 0);
        cyc(0, 0, 1);
        chk("t1_tick3", cnt_of(0), 'h000);
        chk("t1_done", int'(ddone[0]), 1);
        chk("t1_run_fall", int'(drun[0]), 0);
        cyc(0, 0, 0);
        chk("t1_done_once", int'(ddone[0]), 0);

        // Borrow chains.
        loadv(1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk("t2_100_099", cnt_of(0), 'h099);
        chk("t2_zero_a", int'(dzero[0]), 0);
        loadv(0, 1, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk("t2_010_009", cnt_of(0), 'h009);
        chk("t2_zero_b", int'(dzero[0]), 0);

        // Clamping and ignored inputs.
        loadv(15, 10, 9);
        chk("t3_clamp", cnt_of(0), 'h999);
        loadv(0, 0, 0);
        cyc(1, 0, 0);
        chk("t3_start_at_0", int'(drun[0]), 0);
        cyc(0, 0, 1);
        chk("t3_tick_idle_0", cnt_of(0), 'h000);
        chk("t3_no_done_0", int'(ddone[0]), 0);
        loadv(5, 5, 5);
        cyc(0, 0, 1);
        chk("t3_tick_idle", cnt_of(0), 'h555);

        // Simultaneous inputs.
        loadv(0, 2, 0);
        cyc(1, 1, 0);
        chk("t4_start_stop", int'(drun[0]), 0);
        cyc(1, 0, 0);
        chk("t4_run", int'(drun[0]), 1);
        cyc(0, 1, 1);
        chk("t4_stop_tick_cnt", cnt_of(0), 'h020);
        chk("t4_stop_tick_run", int'(drun[0]), 0);
        cyc(1, 0, 0);
        step(1, 7, 7, 7, 0, 0, 1);
        chk("t4_load_tick", cnt_of(0), 'h777);
        chk("t4_load_idle", int'(drun[0]), 0);

        // Reload mode versus stop mode from 002.
        loadv(0, 0, 2);
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk("t5_r1_a", cnt_of(1), 'h001);
        cyc(0, 0, 1);
        chk("t5_r1_b", cnt_of(1), 'h000);
        chk("t5_r1_done", int'(ddone[1]), 1);
        chk("t5_r1_run_b", int'(drun[1]), 1);
        chk("t5_r0_done", int'(ddone[0]), 1);
        cyc(0, 0, 1);
        chk("t5_r1_c", cnt_of(1), 'h002);
        chk("t5_r1_done_c", int'(ddone[1]), 0);
        chk("t5_r0_stays0", cnt_of(0), 'h000);
        cyc(0, 0, 1);
        chk("t5_r1_d", cnt_of(1), 'h001);
        chk("t5_r1_run_d", int'(drun[1]), 1);
        chk("t5_r0_idle", int'(drun[0]), 0);

        // Asynchronous reset mid-cycle while running at 456.
        loadv(4, 5, 6);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("t6_pre_cnt", cnt_of(0), 'h456);
        chk("t6_pre_run", int'(drun[0]), 1);
        #2;
        reset_n = 0;
        #1;
        for (int r = 0; r < 2; r++) begin
            chk($sformatf("t6_async_cnt%0d", r), cnt_of(r), 'h000);
            chk($sformatf("t6_async_run%0d", r), int'(drun[r]), 0);
            chk($sformatf("t6_async_done%0d", r), int'(ddone[r]), 0);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk("t6_after_rel_cnt", cnt_of(0), 'h000);
        chk("t6_after_rel_run", int'(drun[0]), 0);
        chk("t6_after_rel_done", int'(ddone[0]), 0);

        @(negedge clk);
        #1;
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
